// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction-fetch stage.
//            Holds the fetch FSM state encoding, the opcode field position
//            within an instruction word and the default bus widths.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  // Default widths (modules take these as parameter defaults)
  localparam int ADDR_W   = 12;
  localparam int INSTR_W  = 19;
  localparam int OFFSET_W = 8;

  // Opcode occupies the top six bits of the instruction word
  localparam int OPCODE_W   = 6;
  localparam int OPCODE_MSB = INSTR_W - 1;
  localparam int OPCODE_LSB = INSTR_W - OPCODE_W;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_unit_if.sv
//------------------------------------------------------------------------------
// Module   : fetch_unit_if
// Purpose  : Instruction-memory request/acknowledge bus.
// Ports    : imem_req   - fetch request, held until acknowledged
//            imem_addr  - fetch address
//            imem_ack   - one-cycle acknowledge, imem_rdata valid with it
//            imem_rdata - fetched instruction word
// Modports : master (fetch stage), slave (instruction memory)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if #(
  parameter int ADDR_W  = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface : fetch_unit_if

`default_nettype wire

// File: rtl/next_pc_calc.sv
//------------------------------------------------------------------------------
// Module   : next_pc_calc
// Purpose  : Combinational next-PC selection for the fetch stage.
//            Priority const > offset > plus1; a conditional jump that is not
//            taken falls through to pc+1. All arithmetic wraps modulo
//            2^ADDR_W. Flags any select pattern that is not exactly one-hot.
// Ports    : i_pc, i_sel_plus1/offset/const, i_branch_cond, i_jump_const,
//            i_jump_offset (signed) -> o_next_pc, o_sel_illegal
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = fetch_pkg::ADDR_W,
  parameter int OFFSET_W = fetch_pkg::OFFSET_W
) (
  input  logic [ADDR_W-1:0]   i_pc,
  input  logic                i_sel_plus1,
  input  logic                i_sel_offset,
  input  logic                i_sel_const,
  input  logic                i_branch_cond,
  input  logic [ADDR_W-1:0]   i_jump_const,
  input  logic [OFFSET_W-1:0] i_jump_offset,
  output logic [ADDR_W-1:0]   o_next_pc,
  output logic                o_sel_illegal
);

  logic [ADDR_W-1:0] w_pc_plus1;
  logic [ADDR_W-1:0] w_offset_ext;
  logic [ADDR_W-1:0] w_pc_branch;
  logic [2:0]        w_sels;

  assign w_pc_plus1   = i_pc + ADDR_W'(1);
  assign w_offset_ext = {{(ADDR_W-OFFSET_W){i_jump_offset[OFFSET_W-1]}}, i_jump_offset};
  assign w_pc_branch  = i_pc + w_offset_ext;

  always_comb begin
    o_next_pc = w_pc_plus1;
    if (i_sel_const) begin
      o_next_pc = i_jump_const;
    end else if (i_sel_offset && i_branch_cond) begin
      o_next_pc = w_pc_branch;
    end
  end

  // Exactly one select must be high; x & (x-1) clears the lowest set bit,
  // so a non-zero result means more than one select was asserted.
  assign w_sels        = {i_sel_const, i_sel_offset, i_sel_plus1};
  assign o_sel_illegal = (w_sels == 3'b000) || ((w_sels & (w_sels - 3'd1)) != 3'b000);

endmodule : next_pc_calc

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Holds the PC, fetches over a req/ack
//            bus, latches the word into the instruction register and, when
//            execute retires it, advances the PC and counts retirements.
// Ports    : clk, rst_n (async, active low)
//            imem                 - instruction-memory bus (master side)
//            instr, opcode        - instruction register and its opcode field
//            instr_valid, pc      - issued-instruction flag and its address
//            exec_done, sel_PCSrc_*, branch_cond, jump_const, jump_offset,
//            halt                 - retire and next-PC controls
//            sel_err, retired_cnt - sticky illegal-select flag, retire count
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter int                  ADDR_W   = fetch_pkg::ADDR_W,
  parameter int                  INSTR_W  = fetch_pkg::INSTR_W,
  parameter int                  OFFSET_W = fetch_pkg::OFFSET_W,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int                  CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        imem,
  output logic [INSTR_W-1:0]  instr,
  output logic [5:0]          opcode,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   pc,
  input  logic                exec_done,
  input  logic                sel_PCSrc_plus1,
  input  logic                sel_PCSrc_offset,
  input  logic                sel_PCSrc_const,
  input  logic                branch_cond,
  input  logic [ADDR_W-1:0]   jump_const,
  input  logic [OFFSET_W-1:0] jump_offset,
  input  logic                halt,
  output logic                sel_err,
  output logic [CNT_W-1:0]    retired_cnt
);

  import fetch_pkg::*;

  fetch_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_req, w_req_nxt;
  logic               r_err, w_err_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]  w_next_pc;
  logic               w_sel_illegal;

  next_pc_calc #(
    .ADDR_W   (ADDR_W),
    .OFFSET_W (OFFSET_W)
  ) u_next_pc_calc (
    .i_pc          (r_pc),
    .i_sel_plus1   (sel_PCSrc_plus1),
    .i_sel_offset  (sel_PCSrc_offset),
    .i_sel_const   (sel_PCSrc_const),
    .i_branch_cond (branch_cond),
    .i_jump_const  (jump_const),
    .i_jump_offset (jump_offset),
    .o_next_pc     (w_next_pc),
    .o_sel_illegal (w_sel_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_req   <= w_req_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_req_nxt   = r_req;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      FETCH: begin
        // Only an ack to an outstanding request is accepted; this also
        // drops a stray ack in the first cycle after reset release.
        if (r_req && imem.imem_ack) begin
          w_instr_nxt = imem.imem_rdata;
          w_valid_nxt = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = ISSUE;
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          w_pc_nxt    = w_next_pc;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_err_nxt   = r_err | w_sel_illegal;
          // Raise the request together with the new PC so imem_addr is
          // already correct in the first request cycle.
          if (halt) begin
            w_state_nxt = HALTED;
            w_req_nxt   = 1'b0;
          end else begin
            w_state_nxt = FETCH;
            w_req_nxt   = 1'b1;
          end
        end
      end
      HALTED: begin
        w_req_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = FETCH;
        w_req_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;
  assign instr          = r_instr;
  assign opcode         = r_instr[INSTR_W-1 -: OPCODE_W];
  assign instr_valid    = r_valid;
  assign pc             = r_pc;
  assign sel_err        = r_err;
  assign retired_cnt    = r_cnt;

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. Stimulus pushes expected
//            issued instructions into a scoreboard queue; a monitor pops and
//            compares whenever the DUT raises instr_valid.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  localparam int AW = 12;
  localparam int IW = 19;
  localparam int OW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] instr;
  logic [5:0]    opcode;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          exec_done, sel_p1, sel_off, sel_cst, branch_cond, halt;
  logic [AW-1:0] jump_const;
  logic [OW-1:0] jump_offset;
  logic          sel_err;
  logic [CW-1:0] retired_cnt;

  fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) imem_bus ();

  fetch_unit #(
    .ADDR_W(AW), .INSTR_W(IW), .OFFSET_W(OW), .RESET_PC('0), .CNT_W(CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem             (imem_bus),
    .instr            (instr),
    .opcode           (opcode),
    .instr_valid      (instr_valid),
    .pc               (pc),
    .exec_done        (exec_done),
    .sel_PCSrc_plus1  (sel_p1),
    .sel_PCSrc_offset (sel_off),
    .sel_PCSrc_const  (sel_cst),
    .branch_cond      (branch_cond),
    .jump_const       (jump_const),
    .jump_offset      (jump_offset),
    .halt             (halt),
    .sel_err          (sel_err),
    .retired_cnt      (retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int            m_pc  = 0;
  int            m_cnt = 0;
  bit            m_err = 1'b0;
  logic [IW-1:0] m_instr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 0;
    m_cnt = 0;
    m_err = 1'b0;
    m_instr = '0;
  endtask

  // Waits for a request, answers after dly cycles, records the expected issue.
  // exec_done pulses during the wait must not affect a fetching unit.
  task automatic do_fetch(input int dly, input logic [IW-1:0] word);
    int   guard = 0;
    exp_t e;
    while (imem_bus.imem_req !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check("req_timeout", 32'd0, 32'd1);
      return;
    end
    check("fetch_addr", 32'(imem_bus.imem_addr), 32'(m_pc));
    repeat (dly) begin
      exec_done  = 1'($urandom_range(0, 1));
      sel_cst    = 1'b1;
      jump_const = AW'($urandom);
      @(negedge clk);
    end
    exec_done = 1'b0;
    sel_cst   = 1'b0;
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = word;
    e.pc    = AW'(m_pc);
    e.instr = word;
    e.cnt   = CW'(m_cnt);
    e.err   = m_err;
    exp_q.push_back(e);
    m_instr = word;
    @(negedge clk);
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = IW'($urandom);
    check("valid_latency", 32'(instr_valid), 32'd1);
  endtask

  // Idle cycles carry stray acks and halts that must be ignored, then retire.
  task automatic do_exec(input int idle, input bit p1, input bit off, input bit cst,
                         input bit cond, input logic [AW-1:0] jc,
                         input logic [OW-1:0] jo, input bit hlt);
    int s;
    repeat (idle) begin
      halt                = 1'($urandom_range(0, 1));
      imem_bus.imem_ack   = 1'($urandom_range(0, 1));
      imem_bus.imem_rdata = IW'($urandom);
      @(negedge clk);
    end
    halt = 1'b0;
    imem_bus.imem_ack = 1'b0;
    check("instr_held", 32'(instr), 32'(m_instr));
    check("valid_before_exec", 32'(instr_valid), 32'd1);
    exec_done   = 1'b1;
    sel_p1      = p1;
    sel_off     = off;
    sel_cst     = cst;
    branch_cond = cond;
    jump_const  = jc;
    jump_offset = jo;
    halt        = hlt;
    if ((int'(p1) + int'(off) + int'(cst)) != 1) m_err = 1'b1;
    s = $signed(jo);
    if (cst)              m_pc = int'(jc);
    else if (off && cond) m_pc = (m_pc + s + 4096) % 4096;
    else                  m_pc = (m_pc + 1) % 4096;
    m_cnt = (m_cnt + 1) % 65536;
    @(negedge clk);
    exec_done = 1'b0;
    sel_p1 = 1'b0; sel_off = 1'b0; sel_cst = 1'b0; branch_cond = 1'b0;
    halt = 1'b0;
    check("valid_after_exec", 32'(instr_valid), 32'd0);
    check("pc_after_exec", 32'(pc), 32'(m_pc));
    check("cnt_after_exec", 32'(retired_cnt), 32'(m_cnt));
    check("err_after_exec", 32'(sel_err), 32'(m_err));
  endtask

  // Monitor: every new issue must match the oldest expected entry
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (instr_valid && !prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_issue", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("mon_instr", 32'(instr), 32'(e.instr));
            check("mon_opcode", 32'(opcode), 32'(e.instr[IW-1:IW-6]));
            check("mon_pc", 32'(pc), 32'(e.pc));
            check("mon_cnt", 32'(retired_cnt), 32'(e.cnt));
            check("mon_err", 32'(sel_err), 32'(e.err));
          end
        end
        prev = instr_valid;
      end
    end
  end

  initial begin
    bit [2:0] r;
    exec_done = 0; sel_p1 = 0; sel_off = 0; sel_cst = 0; branch_cond = 0;
    halt = 0; jump_const = '0; jump_offset = '0;
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = '0;
    model_reset();

    // Reset state, with an ack arriving during and just after reset
    repeat (3) @(negedge clk);
    check("rst_req", 32'(imem_bus.imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_err", 32'(sel_err), 32'd0);
    check("rst_cnt", 32'(retired_cnt), 32'd0);
    imem_bus.imem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    check("stray_ack_ignored", 32'(instr_valid), 32'd0);
    check("req_after_reset", 32'(imem_bus.imem_req), 32'd1);

    // Minimum latency first fetch
    do_fetch(0, 19'h0A5A5);
    // Wrap pc+1 at all-ones
    do_exec(1, 0, 0, 1, 0, 12'hFFF, 8'h00, 0);
    do_fetch(3, IW'($urandom));
    do_exec(0, 1, 0, 0, 0, 12'h000, 8'h00, 0);
    check("pc_wrap", 32'(pc), 32'h000);
    // Backward branch taken / not taken
    do_fetch(0, IW'($urandom));
    do_exec(0, 0, 0, 1, 0, 12'h010, 8'h00, 0);
    do_fetch(1, IW'($urandom));
    do_exec(2, 0, 1, 0, 1, 12'h000, 8'hF0, 0);
    check("branch_taken", 32'(pc), 32'h000);
    do_fetch(0, IW'($urandom));
    do_exec(0, 0, 0, 1, 0, 12'h010, 8'h00, 0);
    do_fetch(2, IW'($urandom));
    do_exec(1, 0, 1, 0, 0, 12'h000, 8'hF0, 0);
    check("branch_not_taken", 32'(pc), 32'h011);

    // Random legal (one-hot) selects
    for (int i = 0; i < 60; i++) begin
      int k;
      do_fetch($urandom_range(0, 3), IW'($urandom));
      k = $urandom_range(0, 2);
      do_exec($urandom_range(0, 2), (k == 0), (k == 1), (k == 2), 1'($urandom),
              AW'($urandom), OW'($urandom), 0);
    end
    check("err_clean", 32'(sel_err), 32'd0);

    // Illegal double select: const wins, error sticks
    do_fetch(1, IW'($urandom));
    do_exec(0, 1, 0, 1, 0, 12'h3C0, 8'h00, 0);
    check("const_priority", 32'(pc), 32'h3C0);
    check("err_set", 32'(sel_err), 32'd1);
    for (int i = 0; i < 40; i++) begin
      do_fetch($urandom_range(0, 3), IW'($urandom));
      r = 3'($urandom);
      do_exec($urandom_range(0, 2), r[0], r[1], r[2], 1'($urandom),
              AW'($urandom), OW'($urandom), 0);
    end
    check("err_sticky", 32'(sel_err), 32'd1);

    // Halt: no further requests, retires or captures
    do_fetch(0, IW'($urandom));
    do_exec(1, 1, 0, 0, 0, 12'h000, 8'h00, 1);
    for (int i = 0; i < 20; i++) begin
      exec_done = 1'($urandom_range(0, 1));
      sel_p1    = 1'b1;
      imem_bus.imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt_req", 32'(imem_bus.imem_req), 32'd0);
      check("halt_valid", 32'(instr_valid), 32'd0);
    end
    exec_done = 1'b0; sel_p1 = 1'b0; imem_bus.imem_ack = 1'b0;
    check("halt_cnt", 32'(retired_cnt), 32'(m_cnt));
    check("halt_pc", 32'(pc), 32'(m_pc));

    // Leave HALTED by reset, then abort a fetch with reset
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_fetch(0, IW'($urandom));
    do_exec(0, 1, 0, 0, 0, 12'h000, 8'h00, 0);
    check("req_before_abort", 32'(imem_bus.imem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_req_async", 32'(imem_bus.imem_req), 32'd0);
    check("abort_valid", 32'(instr_valid), 32'd0);
    imem_bus.imem_ack = 1'b1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    check("abort_no_capture", 32'(instr_valid), 32'd0);
    check("abort_pc", 32'(pc), 32'd0);

    // Zero selects: error plus fall-through to pc+1
    do_fetch(2, IW'($urandom));
    do_exec(0, 0, 0, 0, 1, 12'h123, 8'h05, 0);
    do_fetch(0, IW'($urandom));
    do_exec(0, 1, 0, 0, 0, 12'h000, 8'h00, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fetch_unit

`default_nettype wire
